inst_fetch_queue: RTL and testbench

Decoupling FIFO between instruction fetch and the ID-stage decoder. Buffers fetched {pc, instruction, fetch-exception} entries so that fetch keeps issuing while ID stalls on hazards. Feeds the decoder one entry per cycle and empties in one cycle on a pipeline flush (branch redirect, exception, ERET).

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue_fifo_ptr.sv | 36 +++
 rtl/inst_fetch_queue.sv | 100 ++++++++++
 tb/tb_inst_fetch_queue.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: the fetch queue entry layout
// and the architectural reset vector also used by the PC generator.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        exc;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INS  = 32'h0;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch-side push channel and ID-side pop channel.
interface inst_fetch_queue_if;

  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic        in_exc;
  logic        in_ready;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_exc;
  logic        out_ready;

  // master: fetch/decode environment; slave: the queue itself
  modport master (
    output in_valid, in_pc, in_ins, in_exc, out_ready,
    input  in_ready, out_valid, out_pc, out_ins, out_exc
  );

  modport slave (
    input  in_valid, in_pc, in_ins, in_exc, out_ready,
    output in_ready, out_valid, out_pc, out_ins, out_exc
  );

endinterface

// File: rtl/inst_fetch_queue_fifo_ptr.sv
// Wrap-bit FIFO pointer: the MSB toggles each time the index wraps, so equal
// indices with differing MSBs mean full. Load has priority over increment.
module fifo_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between instruction fetch and the ID decoder; one-cycle
// flush empties it by snapping the read pointer onto the write pointer.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     resetn,
  inst_fetch_queue_if.slave        q,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  import cpu_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr_inc;
  logic          rd_inc;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  fetch_entry_t  new_entry;
  fetch_entry_t  head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Ready ignores out_ready on purpose: no combinational path from ID back to fetch.
  assign q.in_ready = resetn & ~full;

  assign push   = q.in_valid & q.in_ready;
  assign pop    = q.out_valid & q.out_ready;
  assign wr_inc = push & ~flush;
  assign rd_inc = pop & ~flush;

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (wr_inc),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk      (clk),
    .resetn   (resetn),
    .inc      (rd_inc),
    .load     (flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  always_comb begin
    new_entry.pc  = q.in_pc;
    new_entry.ins = q.in_ins;
    new_entry.exc = q.in_exc;
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_inc) begin
      mem_d[wr_ptr[AW-1:0]] = new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[rd_ptr[AW-1:0]];

  // Empty queue presents a NOP at the reset vector so the decoder sees nothing harmful.
  always_comb begin
    q.out_valid = ~empty;
    q.out_pc    = RESET_PC;
    q.out_ins   = NOP_INS;
    q.out_exc   = 1'b0;
    if (!empty) begin
      q.out_pc  = head.pc;
      q.out_ins = head.ins;
      q.out_exc = head.exc;
    end
  end

  assign count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small reference queue for the
// streaming and random-handshake phases.
module tb_inst_fetch_queue;

  import cpu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] XOR_K = 32'h5a5a0000;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic [2:0] count;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'hbfc00000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (bus.slave),
    .flush  (flush),
    .count  (count)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  int           delivered;
  fetch_entry_t mq[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic e,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_ins    = pc ^ XOR_K;
    bus.in_exc    = e;
    bus.out_ready = rdy;
    flush         = fl;
  endtask

  task automatic mstep(input logic v, input logic [31:0] pc, input logic rdy,
                       output logic accepted);
    fetch_entry_t ent;
    logic do_push;
    logic do_pop;
    drive(v, pc, 1'b0, rdy, 1'b0);
    #1;
    check("m_valid", bus.out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("m_pc",  bus.out_pc,  mq[0].pc);
      check("m_ins", bus.out_ins, mq[0].ins);
      check("m_exc", bus.out_exc, mq[0].exc);
    end
    check("m_count", count, mq.size());
    check("m_ready", bus.in_ready, mq.size() < DEPTH);
    do_push = v && (mq.size() < DEPTH);
    do_pop  = rdy && (mq.size() != 0);
    ent.pc  = pc;
    ent.ins = pc ^ XOR_K;
    ent.exc = 1'b0;
    tick;
    if (do_pop) begin
      void'(mq.pop_front());
      delivered++;
    end
    if (do_push) mq.push_back(ent);
    accepted = do_push;
  endtask

  initial begin
    fetch_entry_t e0;
    logic acc;
    int pushed;
    int stall;

    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    check("rst_in_ready_low", bus.in_ready, 1'b0);
    tick;
    resetn = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_ins",   bus.out_ins,   32'h0);
    check("rst_out_pc",    bus.out_pc,    32'hbfc00000);
    check("rst_count",     count,         3'd0);
    check("rst_in_ready",  bus.in_ready,  1'b1);

    // fill to DEPTH with ID stalled
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h100 + 4 * i), 1'b0, 1'b0, 1'b0);
      tick;
    end
    drive(1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    #1;
    check("full_count",    count,        3'd4);
    check("full_in_ready", bus.in_ready, 1'b0);
    check("full_head",     bus.out_pc,   32'h100);
    tick;
    check("refuse_count",  count,        3'd4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("drain_valid", bus.out_valid, 1'b1);
      check("drain_pc",    bus.out_pc,    32'(32'h100 + 4 * i));
      check("drain_ins",   bus.out_ins,   32'(32'h100 + 4 * i) ^ XOR_K);
      tick;
    end
    check("drained_valid", bus.out_valid, 1'b0);
    check("drained_count", count,         3'd0);
    check("drained_pc",    bus.out_pc,    32'hbfc00000);
    check("drained_ins",   bus.out_ins,   32'h0);

    // simultaneous push and pop at occupancy 2
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    tick;
    drive(1'b1, 32'h308, 1'b0, 1'b1, 1'b0);
    #1;
    check("pp_pre_count", count,      3'd2);
    check("pp_pre_head",  bus.out_pc, 32'h300);
    tick;
    check("pp_count", count,      3'd2);
    check("pp_head",  bus.out_pc, 32'h304);
    mq.delete();
    e0.exc = 1'b0;
    e0.pc = 32'h304; e0.ins = 32'h304 ^ XOR_K; mq.push_back(e0);
    e0.pc = 32'h308; e0.ins = 32'h308 ^ XOR_K; mq.push_back(e0);
    delivered = 0;
    for (int k = 0; k < 20; k++) begin
      mstep(1'($urandom_range(0, 1)), 32'(32'h500 + 4 * k), 1'($urandom_range(0, 1)), acc);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rflush_count", count,         3'd0);
    check("rflush_valid", bus.out_valid, 1'b0);
    mq.delete();

    // stream 11 entries with one ID stall
    delivered = 0;
    pushed    = 0;
    stall     = int'($urandom_range(2, 8));
    for (int c = 0; c < 40; c++) begin
      if (pushed == 11 && mq.size() == 0) break;
      mstep(pushed < 11, 32'(32'h600 + 4 * pushed), c != stall, acc);
      if (acc) pushed++;
    end
    check("wrap_delivered", delivered, 11);

    // flush while full with a push in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(32'h400 + 4 * i), 1'b0, 1'b0, 1'b0);
      tick;
    end
    check("ff_full_count", count, 3'd4);
    drive(1'b1, 32'h410, 1'b0, 1'b0, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("ff_valid",    bus.out_valid, 1'b0);
    check("ff_count",    count,         3'd0);
    check("ff_in_ready", bus.in_ready,  1'b1);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    #1;
    check("nobypass_valid", bus.out_valid, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("post_flush_valid", bus.out_valid, 1'b1);
    check("post_flush_pc",    bus.out_pc,    32'h200);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick;

    // exception tag travels with its PC and is cleared by flush
    drive(1'b1, 32'hbfc00003, 1'b1, 1'b0, 1'b0);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("exc_flag", bus.out_exc, 1'b1);
    check("exc_pc",   bus.out_pc,  32'hbfc00003);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("exc_cleared", bus.out_exc,   1'b0);
    check("exc_empty",   bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
